// File: rtl/event_emitter_if.sv
// Event interface between a control/sequencer master and the event_emitter.
// The master issues burst requests and flushes; the emitter returns strobes and status.
interface event_emitter_if #(
    parameter int unsigned CNT_W = 8
);
    logic             req_valid;
    logic [CNT_W-1:0] req_count;
    logic             req_ready;
    logic             flush;
    logic             evt;
    logic [CNT_W-1:0] evt_idx;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output req_valid, req_count, flush,
        input  req_ready, evt, evt_idx, busy, done, aborted
    );

    modport slave (
        input  req_valid, req_count, flush,
        output req_ready, evt, evt_idx, busy, done, aborted
    );
endinterface

// File: rtl/event_emitter.sv
// Programmable event-pulse generator: one accepted request of N events yields N
// indexed one-cycle evt strobes spaced by GAP idle cycles, closed by done or aborted.
module event_emitter #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic            clk,
    input  logic            rst,
    event_emitter_if.slave  bus
);
    localparam int unsigned GAP_W = 8;
    // Reload value for the inter-event gap counter; unused when GAP is 0.
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP == 0) ? '0 : GAP_W'(GAP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             evt_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;

    logic             ready;
    logic             accept;
    logic             last_evt;
    logic [CNT_W-1:0] idx_next;

    assign ready    = (state == IDLE) && !bus.flush && !rst;
    assign accept   = bus.req_valid && ready;
    assign last_evt = (idx == CNT_W'(count - 1'b1));
    assign idx_next = CNT_W'(idx + 1'b1);

    // Burst sequencer; flush outranks every state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            evt_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            evt_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (bus.flush) begin
                state     <= IDLE;
                busy_q    <= 1'b0;
                aborted_q <= (state != IDLE);
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            count  <= bus.req_count;
                            idx    <= '0;
                            busy_q <= 1'b1;
                            if (bus.req_count == '0) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state <= FIRE;
                                evt_q <= 1'b1;
                            end
                        end
                    end
                    FIRE: begin
                        if (last_evt) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (GAP == 0) begin
                            idx   <= idx_next;
                            evt_q <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            gap_cnt <= GAP_LOAD;
                            idx     <= idx_next;
                        end
                    end
                    WAIT: begin
                        if (gap_cnt == '0) begin
                            state <= FIRE;
                            evt_q <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.evt       = evt_q;
    assign bus.evt_idx   = idx;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
endmodule

// File: tb/tb_event_emitter.sv
// Bench for event_emitter: reset, tabled GAP=2 bursts, GAP=0 sequences, and
// randomized traffic against a timing-formula reference model on GAP=0 and GAP=2 instances.
module tb_event_emitter;
    localparam int unsigned CNT_W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    event_emitter_if #(.CNT_W(CNT_W)) bus0 ();
    event_emitter_if #(.CNT_W(CNT_W)) bus2 ();

    event_emitter #(.CNT_W(CNT_W), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    event_emitter #(.CNT_W(CNT_W), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic       v;
        logic [7:0] c;
        logic       f;
        logic       e;
        logic [7:0] i;
        logic       b;
        logic       dn;
        logic       r;
        logic       a;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] c, logic f, logic e, logic [7:0] i,
                                logic b, logic dn, logic r, logic a);
        vec_t x;
        x.v = v; x.c = c; x.f = f; x.e = e; x.i = i; x.b = b; x.dn = dn; x.r = r; x.a = a;
        return x;
    endfunction

    // {evt, evt_idx (masked when evt=0), busy, done, req_ready, aborted}
    function automatic logic [12:0] pack(logic e, logic [7:0] i, logic b, logic dn,
                                         logic r, logic a);
        return {e, (e ? i : 8'd0), b, dn, r, a};
    endfunction

    function automatic logic [12:0] obs(int d);
        if (d == 0)
            return pack(bus0.evt, bus0.evt_idx, bus0.busy, bus0.done, bus0.req_ready, bus0.aborted);
        return pack(bus2.evt, bus2.evt_idx, bus2.busy, bus2.done, bus2.req_ready, bus2.aborted);
    endfunction

    task automatic check(string name, logic [12:0] act, logic [12:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s t=%0t: got evt=%0b idx=%0d busy=%0b done=%0b ready=%0b aborted=%0b, want evt=%0b idx=%0d busy=%0b done=%0b ready=%0b aborted=%0b",
                     name, $time, act[12], act[11:4], act[3], act[2], act[1], act[0],
                     exp[12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(int d, logic v, logic [7:0] c, logic f);
        if (d == 0) begin
            bus0.req_valid = v; bus0.req_count = c; bus0.flush = f;
        end else begin
            bus2.req_valid = v; bus2.req_count = c; bus2.flush = f;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for the current cycle, then compare this cycle's outputs.
    task automatic step(int d, string name, logic v, logic [7:0] c, logic f, logic e,
                        logic [7:0] i, logic b, logic dn, logic r, logic a);
        drive(d, v, c, f);
        #1;
        check(name, obs(d), pack(e, i, b, dn, r, a));
    endtask

    // Reference model: a burst is "start edge + elapsed cycles", outputs follow from timing formulas.
    int   gap_of[2] = '{0, 2};
    bit   m_act[2];
    int   m_rel[2];
    int   m_n[2];
    bit   m_ab[2];
    bit   p_rst;
    bit   p_v[2];
    bit   p_f[2];
    int   p_c[2];

    function automatic int done_rel(int d);
        return (m_n[d] == 0) ? 1 : (m_n[d] - 1) * (gap_of[d] + 1) + 2;
    endfunction

    task automatic model_edge(int d);
        if (p_rst) begin
            m_act[d] = 1'b0;
            m_ab[d]  = 1'b0;
        end else if (p_f[d]) begin
            m_ab[d]  = m_act[d];
            m_act[d] = 1'b0;
        end else begin
            m_ab[d] = 1'b0;
            if (m_act[d]) begin
                m_rel[d]++;
                if (m_rel[d] > done_rel(d)) m_act[d] = 1'b0;
            end else if (p_v[d]) begin
                m_act[d] = 1'b1;
                m_rel[d] = 1;
                m_n[d]   = p_c[d];
            end
        end
    endtask

    function automatic logic [12:0] model_out(int d, bit cur_f, bit cur_rst);
        int  per;
        bit  e;
        per = gap_of[d] + 1;
        e   = m_act[d] && (m_n[d] > 0) && (m_rel[d] < done_rel(d)) && (((m_rel[d] - 1) % per) == 0);
        return pack(e, 8'((m_rel[d] - 1) / per), m_act[d], m_act[d] && (m_rel[d] == done_rel(d)),
                    !m_act[d] && !cur_f && !cur_rst, m_ab[d]);
    endfunction

    initial begin
        // GAP=2 tabled sequences: N=3, N=0, flush in WAIT then fresh burst, flush in IDLE
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));

        // Reset held with a pending request on the GAP=0 instance
        rst = 1'b1;
        drive(0, 1, 5, 0);
        drive(1, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            step(0, "reset0", 1, 5, 0, 0, 0, 0, 0, 0, 0);
            step(1, "reset2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        rst = 1'b0;
        step(0, "rst_release", 1, 5, 0, 0, 0, 0, 0, 1, 0);
        tick();
        for (int n = 0; n < 5; n++) begin
            step(0, "rst_burst", 0, 0, 0, 1, 8'(n), 1, 0, 0, 0);
            tick();
        end
        step(0, "rst_done", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        step(0, "rst_idle", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();

        foreach (tbl[k]) begin
            step(1, $sformatf("tbl[%0d]", k), tbl[k].v, tbl[k].c, tbl[k].f, tbl[k].e, tbl[k].i,
                 tbl[k].b, tbl[k].dn, tbl[k].r, tbl[k].a);
            tick();
        end

        // GAP=0, N=4, with a stray request mid-burst that must not be queued
        step(0, "g0_acc", 1, 4, 0, 0, 0, 0, 0, 1, 0);
        tick();
        for (int n = 0; n < 4; n++) begin
            step(0, "g0_evt", (n == 2), 7, 0, 1, 8'(n), 1, 0, 0, 0);
            tick();
        end
        step(0, "g0_done", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        step(0, "g0_idle", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        step(0, "g0_noqueue", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();

        // Maximum burst: 255 contiguous strobes
        step(0, "max_acc", 1, 255, 0, 0, 0, 0, 0, 1, 0);
        tick();
        for (int n = 0; n < 255; n++) begin
            step(0, "max_evt", 0, 0, 0, 1, 8'(n), 1, 0, 0, 0);
            tick();
        end
        step(0, "max_done", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        step(0, "max_idle", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();

        // Reset mid-burst drops it silently
        step(0, "mid_acc", 1, 9, 0, 0, 0, 0, 0, 1, 0);
        tick();
        for (int n = 0; n < 3; n++) begin
            step(0, "mid_evt", 0, 0, 0, 1, 8'(n), 1, 0, 0, 0);
            tick();
        end
        rst = 1'b1;
        step(0, "mid_rst_cycle", 0, 0, 0, 1, 8'd3, 1, 0, 0, 0);
        tick();
        step(0, "mid_in_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        step(0, "mid_after1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        step(0, "mid_after2", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();

        // Randomized traffic on both instances against the reference model
        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        tick();
        p_rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            p_v[d] = 1'b0; p_f[d] = 1'b0; p_c[d] = 0;
            m_act[d] = 1'b0; m_ab[d] = 1'b0; m_rel[d] = 0; m_n[d] = 0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic       v[2];
            logic       f[2];
            logic [7:0] c[2];
            for (int d = 0; d < 2; d++) model_edge(d);
            rst = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < 2; d++) begin
                v[d] = ($urandom_range(0, 4) < 2);
                f[d] = ($urandom_range(0, 29) == 0);
                c[d] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                   : 8'($urandom_range(0, 5));
                drive(d, v[d], c[d], f[d]);
            end
            #1;
            for (int d = 0; d < 2; d++)
                check($sformatf("rand_g%0d_c%0d", gap_of[d], cyc), obs(d), model_out(d, f[d], rst));
            p_rst = rst;
            for (int d = 0; d < 2; d++) begin
                p_v[d] = v[d]; p_f[d] = f[d]; p_c[d] = int'(c[d]);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
